// File: rtl/wbu_commit.sv
// rtl/wbu_commit.sv - writeback/commit stage: load extraction, GPR/CSR writeback, done pulse, instret
module wbu_commit #(
   parameter int XLEN      = 32,
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [31:0]          in_inst,
   input  logic [4:0]           in_rd,
   input  logic                 in_rd_wen,
   input  logic [XLEN-1:0]      in_result,
   input  logic                 in_is_load,
   input  logic [1:0]           in_ld_size,
   input  logic                 in_ld_unsigned,
   input  logic [1:0]           in_addr_lo,
   input  logic                 in_csr_wen,
   input  logic [11:0]          in_csr_addr,
   input  logic [XLEN-1:0]      in_csr_wdata,
   input  logic                 in_brk,
   input  logic                 in_ivd,
   input  logic                 lsu_rvalid,
   input  logic [XLEN-1:0]      lsu_rdata,
   output logic                 done,
   output logic [XLEN-1:0]      pc,
   output logic [31:0]          inst,
   output logic                 brk,
   output logic                 ivd,
   output logic                 gpr_wen,
   output logic [31:0]          gpr_waddr,
   output logic [XLEN-1:0]      gpr_wdata,
   output logic                 csr_wen,
   output logic [31:0]          csr_waddr,
   output logic [XLEN-1:0]      csr_wdata,
   output logic [INSTRET_W-1:0] instret
);

   typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

   state_t            state;

   // Fields held while a load waits for its LSU response
   logic [XLEN-1:0]   r_pc;
   logic [31:0]       r_inst;
   logic [4:0]        r_rd;
   logic              r_rd_wen;
   logic [1:0]        r_ld_size;
   logic              r_ld_unsigned;
   logic [1:0]        r_addr_lo;
   logic              r_csr_wen;
   logic [11:0]       r_csr_addr;
   logic [XLEN-1:0]   r_csr_wdata;
   logic              r_brk;
   logic              r_ivd;

   // Pick the addressed byte/half out of the aligned word and extend it;
   // for halfwords only addr bit 1 selects the lane.
   function automatic logic [XLEN-1:0] ld_extract(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      size,
                                                  input logic            uns,
                                                  input logic [1:0]      lo);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = word[{lo[1], 4'b0000} +: 16];
      case (size)
         2'd0:    ld_extract = {{(XLEN-8){b[7] & ~uns}}, b};
         2'd1:    ld_extract = {{(XLEN-16){h[15] & ~uns}}, h};
         default: ld_extract = word;
      endcase
   endfunction

   assign in_ready = (state == IDLE);

   // Accept/wait/commit sequencing with registered commit outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         r_pc          <= '0;
         r_inst        <= '0;
         r_rd          <= '0;
         r_rd_wen      <= 1'b0;
         r_ld_size     <= '0;
         r_ld_unsigned <= 1'b0;
         r_addr_lo     <= '0;
         r_csr_wen     <= 1'b0;
         r_csr_addr    <= '0;
         r_csr_wdata   <= '0;
         r_brk         <= 1'b0;
         r_ivd         <= 1'b0;
         done          <= 1'b0;
         pc            <= '0;
         inst          <= '0;
         brk           <= 1'b0;
         ivd           <= 1'b0;
         gpr_wen       <= 1'b0;
         gpr_waddr     <= '0;
         gpr_wdata     <= '0;
         csr_wen       <= 1'b0;
         csr_waddr     <= '0;
         csr_wdata     <= '0;
         instret       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  r_pc          <= in_pc;
                  r_inst        <= in_inst;
                  r_rd          <= in_rd;
                  r_rd_wen      <= in_rd_wen;
                  r_ld_size     <= in_ld_size;
                  r_ld_unsigned <= in_ld_unsigned;
                  r_addr_lo     <= in_addr_lo;
                  r_csr_wen     <= in_csr_wen;
                  r_csr_addr    <= in_csr_addr;
                  r_csr_wdata   <= in_csr_wdata;
                  r_brk         <= in_brk;
                  r_ivd         <= in_ivd;
                  if (in_is_load) begin
                     state <= WAIT_MEM;
                  end else begin
                     // Non-loads commit straight from the inputs so done appears next cycle
                     state     <= COMMIT;
                     done      <= 1'b1;
                     pc        <= in_pc;
                     inst      <= in_inst;
                     brk       <= in_brk;
                     ivd       <= in_ivd;
                     gpr_wen   <= in_rd_wen && (in_rd != 5'd0) && !in_ivd;
                     gpr_waddr <= {27'd0, in_rd};
                     gpr_wdata <= in_result;
                     csr_wen   <= in_csr_wen && !in_ivd;
                     csr_waddr <= {20'd0, in_csr_addr};
                     csr_wdata <= in_csr_wdata;
                     instret   <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            WAIT_MEM: begin
               if (lsu_rvalid) begin
                  state     <= COMMIT;
                  done      <= 1'b1;
                  pc        <= r_pc;
                  inst      <= r_inst;
                  brk       <= r_brk;
                  ivd       <= r_ivd;
                  gpr_wen   <= r_rd_wen && (r_rd != 5'd0) && !r_ivd;
                  gpr_waddr <= {27'd0, r_rd};
                  gpr_wdata <= ld_extract(lsu_rdata, r_ld_size, r_ld_unsigned, r_addr_lo);
                  csr_wen   <= r_csr_wen && !r_ivd;
                  csr_waddr <= {20'd0, r_csr_addr};
                  csr_wdata <= r_csr_wdata;
                  instret   <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
               end
            end
            COMMIT: begin
               state   <= IDLE;
               done    <= 1'b0;
               brk     <= 1'b0;
               ivd     <= 1'b0;
               gpr_wen <= 1'b0;
               csr_wen <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
